// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default widths and parity helper.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DIV_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Payload is zero-extended by the caller; extra zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Small synchronous FIFO with registered full flag, occupancy count and
// asynchronous active-low reset. Depth must be a power of two.
module uart_tx_fifo_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
    // Full is registered from the next count, so a pop while full cannot admit a push.
    full_d = (count_d == CntW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered asynchronous serial transmitter: bytes enter through a valid/ready FIFO
// and leave LSB first as start/data/[parity]/stop frames on a registered TXD pad.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DIV_W      = DEF_DIV_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                            CLK,
  input  logic                            R,
  input  logic [DIV_W-1:0]                DIV,
  input  logic [DATA_W-1:0]               WDATA,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic                            TXD,
  output logic                            BUSY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_CNT
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;

  logic              bit_end, start_frame, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  uart_tx_fifo_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_buf (
    .clk_i   (CLK),
    .rst_ni  (R),
    .push_i  (WVALID & WREADY),
    .wdata_i (WDATA),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (FIFO_CNT)
  );

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    div_d       = div_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    par_d       = par_q;
    txd_d       = txd_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    bit_end     = (baud_q == '0);

    if (state_q != ST_IDLE && !bit_end) begin
      baud_d = baud_q - DIV_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          baud_d  = div_q;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = div_q;
          shift_d = shift_q >> 1;
          if (idx_q == IdxW'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
            txd_d = shift_d[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          baud_d  = div_q;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
            baud_d = div_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // DIV is sampled only here, so mid-frame changes apply to the next frame.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = ST_START;
      shift_d = fifo_rdata;
      par_d   = calc_parity(32'(fifo_rdata), 1'(PARITY_ODD));
      div_d   = DIV;
      baud_d  = DIV;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign TXD    = txd_q;
  assign BUSY   = (state_q != ST_IDLE);
  assign WREADY = ~fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard of pushed bytes checked against
// cycle-accurate decoding of TXD on a plain and a parity-enabled instance.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        r0, r1;
  logic [15:0] div0, div1;
  logic [7:0]  wdata0, wdata1;
  logic        wvalid0, wvalid1;
  logic        wready0, wready1, txd0, txd1, busy0, busy1;
  logic [2:0]  cnt0, cnt1;

  int          sel = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          last_waits = 0;
  logic [7:0]  exp_q[$];

  logic       txd_s, busy_s, wready_s;
  logic [2:0] cnt_s;
  assign txd_s    = (sel != 0) ? txd1 : txd0;
  assign busy_s   = (sel != 0) ? busy1 : busy0;
  assign wready_s = (sel != 0) ? wready1 : wready0;
  assign cnt_s    = (sel != 0) ? cnt1 : cnt0;

  always #5 clk = ~clk;

  uart_tx_fifo u_dut0 (
    .CLK(clk), .R(r0), .DIV(div0), .WDATA(wdata0), .WVALID(wvalid0),
    .WREADY(wready0), .TXD(txd0), .BUSY(busy0), .FIFO_CNT(cnt0)
  );

  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .CLK(clk), .R(r1), .DIV(div1), .WDATA(wdata1), .WVALID(wvalid1),
    .WREADY(wready1), .TXD(txd1), .BUSY(busy1), .FIFO_CNT(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after the push edge.
  task automatic push(input logic [7:0] b);
    logic acc;
    if (sel != 0) begin wdata1 = b; wvalid1 = 1'b1; end
    else begin wdata0 = b; wvalid0 = 1'b1; end
    acc = wready_s;
    @(posedge clk);
    if (acc === 1'b1) exp_q.push_back(b);
    @(negedge clk);
    wvalid0 = 1'b0;
    wvalid1 = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of the frame against the scoreboard.
  task automatic check_frame(input int div, input bit contig, input string tag);
    int waits, per, bits, n, bad, busyc, b;
    logic [7:0] e, got;
    logic expbit, pbit;
    per = div + 1;
    bits = (sel != 0) ? 11 : 10;
    n = bits * per;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (txd_s !== 1'b0 && waits < 2000);
    last_waits = waits;
    if (txd_s !== 1'b0) begin
      chk({tag, " start timeout"}, 32'(txd_s), 32'd0);
      return;
    end
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    bad = 0; busyc = 0; got = '0; pbit = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      b = c / per;
      if (b == 0) expbit = 1'b0;
      else if (b <= 8) expbit = e[b-1];
      else if (bits == 11 && b == 9) expbit = ^e;
      else expbit = 1'b1;
      if (txd_s !== expbit) bad++;
      if (busy_s === 1'b1) busyc++;
      if (c % per == div / 2) begin
        if (b >= 1 && b <= 8) got[b-1] = txd_s;
        if (bits == 11 && b == 9) pbit = txd_s;
      end
    end
    chk({tag, " bad bit cycles"}, 32'(bad), 32'd0);
    chk({tag, " byte"}, 32'(got), 32'(e));
    chk({tag, " busy cycles"}, 32'(busyc), 32'(n));
    if (bits == 11) chk({tag, " parity"}, 32'(pbit), 32'(^e));
    if (contig) chk({tag, " gap"}, 32'(waits), 32'd1);
  endtask

  initial begin
    int guard, quiet;
    r0 = 1'b0; r1 = 1'b0; div0 = '0; div1 = '0;
    wdata0 = '0; wdata1 = '0; wvalid0 = 1'b0; wvalid1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", 32'(txd0), 32'd1);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset wready", 32'(wready0), 32'd1);
    chk("reset cnt", 32'(cnt0), 32'd0);
    r0 = 1'b1; r1 = 1'b1;
    @(negedge clk);

    // Single byte, DIV=3: latency, bit pattern, 40-cycle busy
    div0 = 16'd3;
    fork
      push(8'h55);
      check_frame(3, 1'b0, "t1");
    join
    chk("t1 latency", 32'(last_waits), 32'd2);
    @(negedge clk);
    chk("t1 busy end", 32'(busy0), 32'd0);
    chk("t1 cnt end", 32'(cnt0), 32'd0);

    // Back-to-back at DIV=0
    div0 = 16'd0;
    fork
      begin push(8'hA5); push(8'h3C); end
      begin check_frame(0, 1'b0, "t2a"); check_frame(0, 1'b1, "t2b"); end
    join
    @(negedge clk);
    chk("t2 busy end", 32'(busy0), 32'd0);

    // Fill the FIFO during a slow frame
    div0 = 16'd7;
    fork
      begin
        push(8'h11);
        repeat (3) @(negedge clk);
        push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        chk("t3 cnt full", 32'(cnt0), 32'd4);
        chk("t3 wready full", 32'(wready0), 32'd0);
        push(8'hEE);
        chk("t3 no push when full", 32'(cnt0), 32'd4);
        guard = 0;
        while (cnt0 === 3'd4 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        chk("t3 cnt after pop", 32'(cnt0), 32'd3);
        chk("t3 wready after pop", 32'(wready0), 32'd1);
      end
      begin
        for (int i = 0; i < 5; i++) check_frame(7, i > 0, "t3");
      end
    join
    @(negedge clk);
    chk("t3 cnt end", 32'(cnt0), 32'd0);

    // Even parity, DIV=1: 22-cycle frames
    sel = 1;
    div1 = 16'd1;
    fork
      begin push(8'h03); push(8'h07); end
      begin check_frame(1, 1'b0, "t4a"); check_frame(1, 1'b1, "t4b"); end
    join
    @(negedge clk);
    chk("t4 busy end", 32'(busy1), 32'd0);
    sel = 0;

    // DIV change mid-frame applies to the next frame only
    div0 = 16'd3;
    fork
      begin push(8'h96); push(8'h69); div0 = 16'd9; end
      begin check_frame(3, 1'b0, "t6a"); check_frame(9, 1'b1, "t6b"); end
    join
    @(negedge clk);

    // Async reset mid-DATA with words queued
    div0 = 16'd3;
    push(8'hFF); push(8'h01); push(8'h02);
    repeat (8) @(negedge clk);
    chk("t5 in frame", 32'(busy0), 32'd1);
    #2 r0 = 1'b0;
    #1;
    chk("t5 rst txd", 32'(txd0), 32'd1);
    chk("t5 rst busy", 32'(busy0), 32'd0);
    chk("t5 rst cnt", 32'(cnt0), 32'd0);
    chk("t5 rst wready", 32'(wready0), 32'd1);
    exp_q.delete();
    @(negedge clk);
    r0 = 1'b1;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd0 === 1'b1 && busy0 === 1'b0) quiet++;
    end
    chk("t5 quiet after reset", 32'(quiet), 32'd40);

    // Reset during a start bit must raise TXD without a clock edge
    push(8'h00);
    @(negedge clk);
    chk("t5 start low", 32'(txd0), 32'd0);
    #2 r0 = 1'b0;
    #1;
    chk("t5 async txd", 32'(txd0), 32'd1);
    exp_q.delete();
    @(negedge clk);
    r0 = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmitter for ETRI050 MPW test chips.
- Accepts parallel bytes from core logic through a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out as an asynchronous 8N1 (optionally parity) frame on one pad.
- Pairs with the on-chip/host-side receiver used for chip bring-up.
- All state elements are intended to map onto DFFSR-type flops (async active-low reset).

Parameters:
- DATA_W, 8, payload bits per frame.
- DIV_W, 16, width of baud divisor input.
- FIFO_DEPTH, 4, FIFO entries (power of 2, >=2).
- PARITY_EN, 0, 1 = insert parity bit after data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0).
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- CLK  in  1  single system clock, rising edge.
- R  in  1  reset, asynchronous, active-low.
- DIV  in  DIV_W  clocks per bit minus 1.
- WDATA  in  DATA_W  byte to send.
- WVALID  in  1  WDATA valid.
- WREADY  out  1  FIFO can accept (registered, = !full).
- TXD  out  1  serial line, idle high, registered.
- BUSY  out  1  frame in progress (state != IDLE).
- FIFO_CNT  out  clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Reset (R=0, async):
  - TXD=1, BUSY=0, WREADY=1, FIFO_CNT=0.
  - FIFO pointers=0, state=IDLE, baud counter=0.
  - Reset mid-frame aborts the frame; TXD returns high immediately without waiting for a clock edge.
- Push: WVALID & WREADY at a rising edge writes WDATA; FIFO_CNT+1 after that edge.
  - WREADY is registered from the count: while full it stays 0 even if a pop occurs in the same cycle, so no push when full.
- Pop: occurs only when leaving IDLE or STOP with FIFO non-empty. Simultaneous push and pop leaves FIFO_CNT unchanged.
- States:
  - IDLE: TXD=1. If FIFO_CNT>0 at an edge, pop into the shift register, latch DIV into div_q, go START.
  - START: TXD=0 for div_q+1 cycles, then DATA, bit index=0.
  - DATA: TXD=shift[0] (LSB first), div_q+1 cycles per bit, shift right. After DATA_W bits, go PARITY if PARITY_EN, else STOP.
  - PARITY: TXD = XOR(data) ^ PARITY_ODD, div_q+1 cycles.
  - STOP: TXD=1 for STOP_BITS*(div_q+1) cycles. At the end, if FIFO non-empty, pop and go directly to START with no idle cycle; else go IDLE.
- Baud counter: loads div_q on every bit start, decrements each cycle; a bit ends when the counter is 0.
  - DIV=0 gives 1 cycle per bit.
  - DIV changes mid-frame are ignored (div_q is latched at frame start).
- Latency: a word pushed at edge k into an empty FIFO with state IDLE is popped at edge k+1; TXD falls after edge k+1.
- Frame length: (1+DATA_W+PARITY_EN+STOP_BITS)*(DIV+1) cycles.
- BUSY rises with the START entry and falls on STOP->IDLE.
- FIFO pointers wrap modulo FIFO_DEPTH. Full is FIFO_CNT==FIFO_DEPTH; empty is FIFO_CNT==0.
- No X on outputs after reset. WDATA is don't-care when WVALID=0.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit binary);
  - default DATA_W/DIV_W localparams;
  - the parity function.
  The matching receiver reuses this package.
- One sub-module, uart_tx_fifo_buf: synchronous FIFO with push/pop, full/empty and count, async active-low reset.
- FSM, baud counter and shift register stay in the top module.

Test Plan:
- DIV=3, push 0x55 once:
  - TXD low 4 cycles starting the cycle after pop, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles;
  - BUSY high exactly 40 cycles; FIFO_CNT returns to 0.
- DIV=0, push 0xA5,0x3C back-to-back: two contiguous 10-cycle frames with no idle gap; the second start bit directly follows the first stop bit.
- DIV=7, push 5 words while the first frame is sending:
  - WREADY=0 once FIFO_CNT=4;
  - WREADY returns 1 the cycle after the next pop;
  - all 5 bytes appear in order.
- PARITY_EN=1, PARITY_ODD=0, DIV=1:
  - 0x03 gives parity bit 0; 0x07 gives parity bit 1;
  - frame = 22 cycles.
- Assert R low mid-DATA of 0xFF frame with 2 words queued:
  - TXD=1, BUSY=0, FIFO_CNT=0, WREADY=1 asynchronously;
  - after release, no output until a new push.
- DIV changed from 3 to 9 during a frame: the current frame keeps 4-cycle bits; the next queued frame uses 10-cycle bits.
